// File: rtl/iir_pkg.sv
// iir_pkg: shared types, coefficient codes and width helpers for the IIR filter blocks
package iir_pkg;
  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  typedef logic [2:0] tap_t;
  function automatic int acc_w(input int dw, input int cw);
    return dw + cw + 3;
  endfunction
endpackage

// File: rtl/iir_biquad_mc_if.sv
// iir_biquad_mc_if: sample stream, result stream and coefficient/flush controls of the biquad
interface iir_biquad_mc_if #(
  parameter int DW  = 8,
  parameter int CW  = 8,
  parameter int CHW = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CHW-1:0]        in_ch;
  logic signed [DW-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CHW-1:0]        out_ch;
  logic signed [DW-1:0]  out_data;
  logic                  out_sat;
  logic                  coef_we;
  logic [CHW-1:0]        coef_ch;
  logic [2:0]            coef_sel;
  logic signed [CW-1:0]  coef_data;
  logic                  flush;
  modport master (
    output in_valid, in_ch, in_data, out_ready, coef_we, coef_ch, coef_sel, coef_data, flush,
    input  in_ready, out_valid, out_ch, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_ch, in_data, out_ready, coef_we, coef_ch, coef_sel, coef_data, flush,
    output in_ready, out_valid, out_ch, out_data, out_sat
  );
endinterface

// File: rtl/iir_round_sat.sv
// iir_round_sat: arithmetic shift of a pre-rounded accumulator down to DW bits with saturation
module iir_round_sat #(
  parameter int ACC_W = 19,
  parameter int DW    = 8,
  parameter int FRAC  = 6
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [DW-1:0]    y,
  output logic                    sat
);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  logic signed [ACC_W-1:0] q;
  // drop fraction bits, then clip to the DW-bit signed range
  always_comb begin
    q   = acc >>> FRAC;
    sat = (q > MAXV) || (q < MINV);
    y   = q > MAXV ? MAXV[DW-1:0] : q < MINV ? MINV[DW-1:0] : q[DW-1:0];
  end
endmodule

// File: rtl/iir_biquad_mc.sv
// iir_biquad_mc: multichannel Direct Form I biquad sharing one multiplier over five MAC cycles
module iir_biquad_mc import iir_pkg::*; #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int FRAC = 6,
  parameter int CH   = 2,
  parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input logic clk,
  input logic reset,
  iir_biquad_mc_if.slave bus
);
  localparam int ACC_W = acc_w(DW, CW);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC - 1);
  state_t                  state;
  tap_t                    tap;
  logic [CHW-1:0]          ch;
  logic signed [DW-1:0]    x;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [CW-1:0]    c;
  logic signed [DW-1:0]    s;
  logic signed [DW+CW-1:0] prod;
  logic signed [DW-1:0]    y;
  logic                    sat;
  logic                    rdy;
  logic                    ovld;
  logic [CHW-1:0]          och;
  logic signed [DW-1:0]    odata;
  logic                    osat;
  logic signed [CW-1:0]    coef [CH][5];
  logic signed [DW-1:0]    x1 [CH];
  logic signed [DW-1:0]    x2 [CH];
  logic signed [DW-1:0]    y1 [CH];
  logic signed [DW-1:0]    y2 [CH];
  assign bus.in_ready  = rdy;
  assign bus.out_valid = ovld;
  assign bus.out_ch    = och;
  assign bus.out_data  = odata;
  assign bus.out_sat   = osat;
  // pick the coefficient/operand pair for the current tap; feedback taps subtract
  always_comb begin
    c       = coef[ch][tap];
    s       = tap == COEF_B0 ? x : tap == COEF_B1 ? x1[ch] : tap == COEF_B2 ? x2[ch] :
              tap == COEF_A1 ? y1[ch] : y2[ch];
    prod    = c * s;
    acc_nxt = tap >= COEF_A1 ? acc - ACC_W'(prod) : acc + ACC_W'(prod);
  end
  iir_round_sat #(.ACC_W(ACC_W), .DW(DW), .FRAC(FRAC)) u_rs (.acc(acc_nxt), .y(y), .sat(sat));
  // control FSM: accept, five MAC taps, hold the result until downstream takes it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tap   <= '0;
      ch    <= '0;
      x     <= '0;
      acc   <= '0;
      rdy   <= 1'b1;
      ovld  <= 1'b0;
      och   <= '0;
      odata <= '0;
      osat  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && 32'(bus.in_ch) < CH) begin
          ch    <= bus.in_ch;
          x     <= bus.in_data;
          acc   <= RND;
          tap   <= '0;
          rdy   <= 1'b0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_nxt;
          tap <= tap == COEF_A2 ? '0 : tap + 3'd1;
          if (tap == COEF_A2) begin
            odata <= y;
            osat  <= sat;
            och   <= ch;
            ovld  <= 1'b1;
            state <= OUT;
          end
        end
        OUT: if (bus.out_ready) begin
          ovld  <= 1'b0;
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // coefficient RAM, writable only while idle so an in-flight sample sees stable taps
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < CH; i++)
        for (int j = 0; j < 5; j++)
          coef[i][j] <= '0;
    end else if (state == IDLE && bus.coef_we && bus.coef_sel <= COEF_A2 && 32'(bus.coef_ch) < CH) begin
      coef[bus.coef_ch][bus.coef_sel] <= bus.coef_data;
    end
  // per-channel delay lines: flushed while idle, shifted on the output handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (state == IDLE && bus.flush) begin
      for (int i = 0; i < CH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (state == OUT && bus.out_ready) begin
      x2[ch] <= x1[ch];
      x1[ch] <= x;
      y2[ch] <= y1[ch];
      y1[ch] <= odata;
    end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb_iir_biquad_mc: directed vectors with hand-computed results for the multichannel biquad
module tb_iir_biquad_mc;
  localparam int DW = 8, CW = 8, FRAC = 6, CH = 2, CHW = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int dec[6] = '{100, 50, 25, 13, 7, 4};
  int saw;
  iir_biquad_mc_if #(.DW(DW), .CW(CW), .CHW(CHW)) bus ();
  iir_biquad_mc #(.DW(DW), .CW(CW), .FRAC(FRAC), .CH(CH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic wcoef(input int c, input int sel, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_ch   = CHW'(c);
    bus.coef_sel  = 3'(sel);
    bus.coef_data = CW'(d);
    @(posedge clk); #1;
    bus.coef_we   = 1'b0;
  endtask
  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask
  task automatic send(input int c, input int xv, input int hold, input bit bw, input int ey, input int es);
    int lat = 0;
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_ch    = CHW'(c);
    bus.in_data  = DW'(xv);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (bw) begin
      bus.coef_we   = 1'b1;
      bus.coef_ch   = CHW'(c);
      bus.coef_sel  = 3'd0;
      bus.coef_data = '0;
    end
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      lat++;
    end
    check("latency", lat, 5);
    check("out_data", int'($signed(bus.out_data)), ey);
    check("out_sat", bus.out_sat, es);
    check("out_ch", bus.out_ch, c);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", int'($signed(bus.out_data)), ey);
      check("hold_ch", bus.out_ch, c);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_ch   = '0;
    bus.coef_sel  = '0;
    bus.coef_data = '0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_data", int'($signed(bus.out_data)), 0);
    check("rst_out_sat", bus.out_sat, 0);
    wcoef(0, 0, 64);
    send(0, 5, 0, 1'b0, 5, 0);
    wcoef(0, 3, -32);
    do_flush();
    for (int i = 0; i < 6; i++) send(0, i == 0 ? 100 : 0, 0, 1'b0, dec[i], 0);
    do_flush();
    send(0, 0, 0, 1'b0, 0, 0);
    wcoef(0, 3, 0);
    wcoef(0, 0, 127);
    send(0, 100, 0, 1'b0, 127, 1);
    send(0, -100, 0, 1'b0, -128, 1);
    send(0, 1, 0, 1'b0, 2, 0);
    wcoef(0, 0, 64);
    wcoef(0, 3, -32);
    wcoef(1, 0, 64);
    do_flush();
    send(0, 100, 0, 1'b0, 100, 0);
    send(1, 10, 0, 1'b0, 10, 0);
    send(0, 0, 0, 1'b0, 50, 0);
    send(1, 0, 0, 1'b0, 0, 0);
    send(1, 20, 3, 1'b0, 20, 0);
    send(1, 30, 0, 1'b1, 30, 0);
    send(1, 40, 0, 1'b0, 40, 0);
    bus.in_valid = 1'b1;
    bus.in_ch    = '0;
    bus.in_data  = DW'(5);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    saw = 0;
    repeat (3) begin
      @(posedge clk); #1;
      saw |= int'(bus.out_valid);
    end
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      saw |= int'(bus.out_valid);
    end
    check("rst_abort_no_valid", saw, 0);
    check("rst_abort_in_ready", bus.in_ready, 1);
    wcoef(0, 0, 64);
    send(0, 5, 0, 1'b0, 5, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
